// File: rtl/iclass_pred_table_pkg.sv
// Shared types for the instruction-class predictor: class vector, table entry
// layout, training operations and the confidence helpers.
package iclass_pkg;

    // Entry format. The table is tagged with PC bits just above the index.
    localparam int TAG_BITS  = 8;
    localparam int CONF_BITS = 2;

    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
    localparam logic [CONF_BITS-1:0] CONF_ONE = CONF_BITS'(1);

    // {Call,Return,Jump,Branch}; never assumed one-hot.
    typedef struct packed {
        logic call;
        logic ret;
        logic jump;
        logic branch;
    } iclass_t;

    typedef struct packed {
        logic [TAG_BITS-1:0]  tag;
        iclass_t              iClass;
        logic [CONF_BITS-1:0] conf;
    } iclass_entry_t;

    // What the M-stage training step does to the indexed entry.
    typedef enum logic [2:0] {
        UPD_NONE,
        UPD_ALLOC,
        UPD_INC,
        UPD_DEC,
        UPD_REPLACE,
        UPD_INVAL
    } upd_op_t;

    // A prediction is trusted once the confidence counter reaches its upper half.
    function automatic logic confTrusted(input logic [CONF_BITS-1:0] conf);
        return conf[CONF_BITS-1];
    endfunction

endpackage

// File: rtl/iclass_pred_table_if.sv
// Pipeline-side bundle of the class predictor: stalls/flushes, lookup and
// update addresses, decoded/resolved classes and the prediction outputs.
interface iclass_pred_table_if #(
    parameter int XLEN = 64
);
    import iclass_pkg::*;

    logic            StallF, StallD, StallE, StallM;
    logic            FlushD, FlushE, FlushM;
    logic            FlushTable;
    logic [XLEN-1:0] PCNextF;
    logic [XLEN-1:0] PCM;
    iclass_t         ClassD;
    iclass_t         ClassM;
    iclass_t         BPClassF;
    logic            BPHitF;
    logic            IClassWrongM;
    logic            BPReturnWrongD;

    // Pipeline / IFU side.
    modport master (
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushM, FlushTable,
        output PCNextF, PCM, ClassD, ClassM,
        input  BPClassF, BPHitF, IClassWrongM, BPReturnWrongD
    );

    // Predictor side.
    modport slave (
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushM, FlushTable,
        input  PCNextF, PCM, ClassD, ClassM,
        output BPClassF, BPHitF, IClassWrongM, BPReturnWrongD
    );

endinterface

// File: rtl/iclass_pred_table_ram.sv
// Predictor storage: entry array with a registered lookup port and a
// read-modify-write training port. Valid bits live in flops so the whole
// table can be invalidated in one cycle.
module iclass_pred_ram
    import iclass_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clearAll,
    input  logic          rdEn,
    input  logic [IW-1:0] rdIdx,
    output logic          rdValid,
    output iclass_entry_t rdEntry,
    input  logic [IW-1:0] updIdx,
    output logic          updValid,
    output iclass_entry_t updEntry,
    input  logic          wrEn,
    input  logic          wrValid,
    input  iclass_entry_t wrEntry
);

    iclass_entry_t    mem [DEPTH];
    logic [DEPTH-1:0] validReg;
    logic [DEPTH-1:0] validNext;
    logic             rdBypass;

    // Training port sees the current entry without a cycle of delay.
    assign updEntry = mem[updIdx];
    assign updValid = validReg[updIdx];
    assign rdBypass = wrEn && (updIdx == rdIdx);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gValid
            assign validNext[gi] = (wrEn && (updIdx == IW'(gi))) ? wrValid : validReg[gi];
        end
    endgenerate

    // Entry payload write; contents of invalid entries are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (wrEn)
            mem[updIdx] <= wrEntry;
    end

    // Valid vector: reset and table flush both clear every entry.
    always_ff @(posedge clk) begin
        if (!reset || clearAll)
            validReg <= '0;
        else
            validReg <= validNext;
    end

    // Lookup valid, write-first when training hits the same index.
    always_ff @(posedge clk) begin
        if (!reset || clearAll)
            rdValid <= 1'b0;
        else if (rdEn)
            rdValid <= rdBypass ? wrValid : validReg[rdIdx];
    end

    // Lookup payload, write-first; qualified by rdValid downstream.
    always_ff @(posedge clk) begin
        if (rdEn)
            rdEntry <= rdBypass ? wrEntry : mem[rdIdx];
    end

endmodule

// File: rtl/iclass_pred_table.sv
// Learning instruction-class predictor: fetch lookup, F->D->E->M
// misprediction tracking and M-stage training of a tagged table.
module iclass_pred_table
    import iclass_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 64,
    parameter int ZCA   = 1
) (
    input  logic          clk,
    input  logic          reset,
    iclass_pred_table_if.slave bus
);

    localparam int IW  = $clog2(DEPTH);
    localparam int LSB = (ZCA != 0) ? 1 : 2;

    logic [IW-1:0]       lookupIdx, updIdx;
    logic [TAG_BITS-1:0] lookupTag, updTag, tagFReg;
    logic                rdValid, updValid, updHit, fire, wrEn, wrValid, fetchHit;
    iclass_entry_t       rdEntry, updEntry, wrEntry;
    upd_op_t             updOp;
    iclass_t             bpClassDReg;
    logic                wrongD, wrongEReg, wrongMReg;

    assign lookupIdx = bus.PCNextF[LSB +: IW];
    assign lookupTag = bus.PCNextF[LSB+IW +: TAG_BITS];
    assign updIdx    = bus.PCM[LSB +: IW];
    assign updTag    = bus.PCM[LSB+IW +: TAG_BITS];

    iclass_pred_ram #(.DEPTH(DEPTH)) uRam (
        .clk      (clk),
        .reset    (reset),
        .clearAll (bus.FlushTable),
        .rdEn     (!bus.StallF),
        .rdIdx    (lookupIdx),
        .rdValid  (rdValid),
        .rdEntry  (rdEntry),
        .updIdx   (updIdx),
        .updValid (updValid),
        .updEntry (updEntry),
        .wrEn     (wrEn),
        .wrValid  (wrValid),
        .wrEntry  (wrEntry)
    );

    // Tag of the PC now in F, captured alongside the table read.
    always_ff @(posedge clk) begin
        if (!reset)
            tagFReg <= '0;
        else if (!bus.StallF)
            tagFReg <= lookupTag;
    end

    assign fetchHit     = rdValid && (rdEntry.tag == tagFReg);
    assign bus.BPHitF   = fetchHit;
    assign bus.BPClassF = (fetchHit && confTrusted(rdEntry.conf)) ? rdEntry.iClass : '0;

    // F->D prediction register; flush wins over stall.
    always_ff @(posedge clk) begin
        if (!reset || bus.FlushD)
            bpClassDReg <= '0;
        else if (!bus.StallD)
            bpClassDReg <= bus.BPClassF;
    end

    assign wrongD             = |(bpClassDReg ^ bus.ClassD);
    assign bus.BPReturnWrongD = bpClassDReg.ret ^ bus.ClassD.ret;

    // D->E misprediction flag.
    always_ff @(posedge clk) begin
        if (!reset || bus.FlushE)
            wrongEReg <= 1'b0;
        else if (!bus.StallE)
            wrongEReg <= wrongD;
    end

    // E->M misprediction flag.
    always_ff @(posedge clk) begin
        if (!reset || bus.FlushM)
            wrongMReg <= 1'b0;
        else if (!bus.StallM)
            wrongMReg <= wrongEReg;
    end

    assign bus.IClassWrongM = wrongMReg;

    // Training decision against the entry as it stands now, not as seen in F.
    always_comb begin
        updOp   = UPD_NONE;
        wrEntry = updEntry;
        wrValid = 1'b1;
        updHit  = updValid && (updEntry.tag == updTag);
        fire    = !bus.StallM && !bus.FlushM && ((bus.ClassM != '0) || updHit);
        if (fire) begin
            if (!updHit)
                updOp = (bus.ClassM != '0) ? UPD_ALLOC : UPD_NONE;
            else if (updEntry.iClass == bus.ClassM)
                updOp = UPD_INC;
            else if (updEntry.conf != '0)
                updOp = UPD_DEC;
            else if (bus.ClassM != '0)
                updOp = UPD_REPLACE;
            else
                updOp = UPD_INVAL;
        end
        case (updOp)
            UPD_ALLOC, UPD_REPLACE: begin
                wrEntry.tag    = updTag;
                wrEntry.iClass = bus.ClassM;
                wrEntry.conf   = CONF_ONE;
            end
            UPD_INC:   if (updEntry.conf != CONF_MAX) wrEntry.conf = updEntry.conf + CONF_ONE;
            UPD_DEC:   wrEntry.conf = updEntry.conf - CONF_ONE;
            UPD_INVAL: wrValid = 1'b0;
            default:   ;
        endcase
        // Reset and a table flush both suppress the write.
        wrEn = (updOp != UPD_NONE) && reset && !bus.FlushTable;
    end

endmodule

// File: tb/tb_iclass_pred_table.sv
// Directed bench for the instruction-class predictor.
module tb_iclass_pred_table;
    import iclass_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;

    iclass_pred_table_if #(.XLEN(64)) bus ();

    iclass_pred_table #(.XLEN(64), .DEPTH(64), .ZCA(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] CALL = 4'b1000;
    localparam logic [3:0] RET  = 4'b0100;
    localparam logic [3:0] JMP  = 4'b0010;
    localparam logic [3:0] BR   = 4'b0001;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
            $display("ok   %s = %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle training pulse at pc, then park PCM on an address with no entry.
    task automatic upd(input logic [63:0] pc, input logic [3:0] cls);
        bus.PCM    = pc;
        bus.ClassM = cls;
        step(1);
        bus.ClassM = '0;
        bus.PCM    = '0;
    endtask

    task automatic look(input logic [63:0] pc);
        bus.PCNextF = pc;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.StallF = 0; bus.StallD = 0; bus.StallE = 0; bus.StallM = 0;
        bus.FlushD = 0; bus.FlushE = 0; bus.FlushM = 0; bus.FlushTable = 0;
        bus.PCNextF = 64'h1000; bus.PCM = '0; bus.ClassD = '0; bus.ClassM = '0;
        step(3);
        reset = 1'b1;
        checkVal("rst_hit",   bus.BPHitF, 0);
        checkVal("rst_class", bus.BPClassF, 0);
        checkVal("rst_wrongM", bus.IClassWrongM, 0);
        checkVal("rst_retD",  bus.BPReturnWrongD, 0);

        // Cold miss, allocate, then train up and saturate.
        look(64'h1000);
        checkVal("cold_hit", bus.BPHitF, 0);
        checkVal("cold_class", bus.BPClassF, 0);
        upd(64'h1000, JMP);
        look(64'h1000);
        checkVal("alloc_hit", bus.BPHitF, 1);
        checkVal("alloc_class_conf1", bus.BPClassF, 0);
        upd(64'h1000, JMP);
        look(64'h1000);
        checkVal("conf2_class", bus.BPClassF, JMP);
        upd(64'h1000, JMP);
        upd(64'h1000, JMP);
        upd(64'h1000, CALL);
        look(64'h1000);
        checkVal("sat_then_dec_class", bus.BPClassF, JMP);
        upd(64'h1000, CALL);
        look(64'h1000);
        checkVal("conf1_class", bus.BPClassF, 0);
        checkVal("conf1_hit", bus.BPHitF, 1);
        upd(64'h1000, CALL);
        upd(64'h1000, CALL);
        look(64'h1000);
        checkVal("replace_hit", bus.BPHitF, 1);
        checkVal("replace_class", bus.BPClassF, 0);
        upd(64'h1000, CALL);
        look(64'h1000);
        checkVal("replace_conf2_class", bus.BPClassF, CALL);

        // Resolving as no-class drains confidence then invalidates.
        upd(64'h1000, 4'b0000);
        upd(64'h1000, 4'b0000);
        look(64'h1000);
        checkVal("drain_hit", bus.BPHitF, 1);
        upd(64'h1000, 4'b0000);
        look(64'h1000);
        checkVal("inval_hit", bus.BPHitF, 0);

        // Alias: same index, different tag, second allocation replaces first.
        upd(64'h1000, BR);
        upd(64'h1080, CALL);
        look(64'h1000);
        checkVal("alias_old_hit", bus.BPHitF, 0);
        look(64'h1080);
        checkVal("alias_new_hit", bus.BPHitF, 1);
        upd(64'h1080, CALL);
        look(64'h1080);
        checkVal("alias_new_class", bus.BPClassF, CALL);

        // Misprediction pipeline with fetch held on a Call prediction.
        bus.ClassD = CALL;
        step(4);
        checkVal("pipe_right_wrongM", bus.IClassWrongM, 0);
        checkVal("pipe_right_retD", bus.BPReturnWrongD, 0);
        bus.ClassD = BR;
        step(3);
        checkVal("pipe_wrong_wrongM", bus.IClassWrongM, 1);
        bus.ClassD = RET;
        #1;
        checkVal("retD_comb", bus.BPReturnWrongD, 1);
        bus.ClassD = '0;
        step(3);
        checkVal("noclass_wrongM", bus.IClassWrongM, 1);
        bus.FlushD = 1;
        step(4);
        checkVal("flushD_wrongM", bus.IClassWrongM, 0);
        bus.FlushD = 0;
        step(3);
        checkVal("unflush_wrongM", bus.IClassWrongM, 1);

        // StallM holds M and blocks training.
        bus.StallM = 1; bus.ClassD = CALL; bus.PCM = 64'h1080; bus.ClassM = BR;
        step(4);
        checkVal("stallM_hold", bus.IClassWrongM, 1);
        bus.StallM = 0; bus.ClassM = '0; bus.PCM = '0;
        step(1);
        checkVal("stallM_noupd_class", bus.BPClassF, CALL);
        step(2);
        checkVal("stallM_release", bus.IClassWrongM, 0);
        bus.ClassD = '0;
        step(3);
        bus.FlushM = 1;
        step(1);
        checkVal("flushM_clear", bus.IClassWrongM, 0);
        bus.FlushM = 0;
        bus.ClassD = '0;

        // Table flush wins over a same-cycle allocation.
        bus.FlushTable = 1; bus.PCM = 64'h2000; bus.ClassM = JMP;
        step(1);
        bus.FlushTable = 0; bus.ClassM = '0; bus.PCM = '0;
        look(64'h2000);
        checkVal("ftab_new_hit", bus.BPHitF, 0);
        look(64'h1080);
        checkVal("ftab_old_hit", bus.BPHitF, 0);

        // Same-index lookup and update: lookup returns post-update entry.
        bus.PCNextF = 64'h3000; bus.PCM = 64'h3000; bus.ClassM = BR;
        step(1);
        bus.ClassM = '0; bus.PCM = '0;
        checkVal("bypass_alloc_hit", bus.BPHitF, 1);
        checkVal("bypass_alloc_class", bus.BPClassF, 0);
        bus.PCM = 64'h3000; bus.ClassM = BR;
        step(1);
        bus.ClassM = '0; bus.PCM = '0;
        checkVal("bypass_inc_class", bus.BPClassF, BR);

        // Reset beats a concurrent allocation.
        reset = 0; bus.PCM = 64'h4000; bus.ClassM = CALL;
        step(1);
        reset = 1; bus.ClassM = '0; bus.PCM = '0;
        checkVal("rst_mid_hit", bus.BPHitF, 0);
        look(64'h4000);
        checkVal("rst_mid_noalloc", bus.BPHitF, 0);
        look(64'h3000);
        checkVal("rst_cleared_valid", bus.BPHitF, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
